// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, clear-FSM encoding and read-port select helper
//               for the multi-port register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_NB_DATA_DEF    = 32;
    localparam int c_NB_ADDR_DEF    = 5;
    localparam int c_BANK_DEPTH_DEF = 32;
    localparam int c_N_READ_DEF     = 2;
    localparam int c_LINK_REG_DEF   = 31;
    localparam int c_ZERO_REG_DEF   = 1;
    localparam int c_BYPASS_DEF     = 1;

    // Addresses are widened to this width inside the helper so one function
    // serves every NB_ADDR the bank may be built with.
    localparam int c_SEL_ADDR_W = 16;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    typedef struct packed {
        logic [c_SEL_ADDR_W-1:0] addr;
        logic                    bypass;
    } rd_sel_t;

    function automatic rd_sel_t rd_select(
        input logic                    link_sel,
        input logic [c_SEL_ADDR_W-1:0] rd_addr,
        input logic [c_SEL_ADDR_W-1:0] link_addr,
        input logic                    wr_en,
        input logic [c_SEL_ADDR_W-1:0] wr_addr,
        input logic                    fsm_idle,
        input logic                    bypass_en
    );
        rd_sel_t s;
        s.addr   = link_sel ? link_addr : rd_addr;
        s.bypass = bypass_en && wr_en && fsm_idle && (wr_addr == s.addr);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_fsm
// Description : Soft-clear sequencer: walks every register once, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NB_ADDR    = c_NB_ADDR_DEF,
    parameter int BANK_DEPTH = c_BANK_DEPTH_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    output logic               o_busy,
    output logic               o_clr_en,
    output logic [NB_ADDR-1:0] o_clr_addr
);

    localparam logic [NB_ADDR-1:0] c_LAST = NB_ADDR'(BANK_DEPTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [NB_ADDR-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            // Counter idles at 0 so CLEAR always starts from register 0.
            if (r_state == c_ST_CLEAR && r_cnt != c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (i_clear)         w_state_next = c_ST_CLEAR;
            c_ST_CLEAR: if (r_cnt == c_LAST) w_state_next = c_ST_IDLE;
            default:                         w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state == c_ST_CLEAR);
        o_clr_en   = (r_state == c_ST_CLEAR);
        o_clr_addr = r_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register bank with link override, write-first
//               bypass, stall hold, debug read port and soft-clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NB_DATA    = c_NB_DATA_DEF,
    parameter int NB_ADDR    = c_NB_ADDR_DEF,
    parameter int BANK_DEPTH = c_BANK_DEPTH_DEF,
    parameter int N_READ     = c_N_READ_DEF,
    parameter int LINK_REG   = c_LINK_REG_DEF,
    parameter int ZERO_REG   = c_ZERO_REG_DEF,
    parameter int BYPASS     = c_BYPASS_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_stall,
    input  logic [N_READ-1:0]         i_link_sel,
    input  logic [N_READ*NB_ADDR-1:0] i_read_reg,
    output logic [N_READ*NB_DATA-1:0] o_data,
    input  logic                      i_reg_write,
    input  logic [NB_ADDR-1:0]        i_write_reg,
    input  logic [NB_DATA-1:0]        i_write_data,
    input  logic [NB_ADDR-1:0]        i_dbg_addr,
    output logic [NB_DATA-1:0]        o_dbg_data,
    input  logic                      i_clear,
    output logic                      o_busy
);

    localparam logic [c_SEL_ADDR_W-1:0] c_DEPTH = c_SEL_ADDR_W'(BANK_DEPTH);
    localparam logic [c_SEL_ADDR_W-1:0] c_LINK  = c_SEL_ADDR_W'(LINK_REG);
    localparam logic                    c_ZERO  = (ZERO_REG != 0);
    localparam logic                    c_BYP   = (BYPASS != 0);

    logic [NB_DATA-1:0]      r_regs [BANK_DEPTH];
    logic [NB_DATA-1:0]      r_dbg;
    logic                    w_busy;
    logic                    w_idle;
    logic                    w_clr_en;
    logic [NB_ADDR-1:0]      w_clr_addr;
    logic [c_SEL_ADDR_W-1:0] w_wr_addr_x;
    logic [c_SEL_ADDR_W-1:0] w_dbg_addr_x;
    logic                    w_wr_ok;

    regfile_clear_fsm #(
        .NB_ADDR    (NB_ADDR),
        .BANK_DEPTH (BANK_DEPTH)
    ) u_clear_fsm (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (i_clear),
        .o_busy     (w_busy),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    assign w_idle       = !w_busy;
    assign o_busy       = w_busy;
    assign w_wr_addr_x  = c_SEL_ADDR_W'(i_write_reg);
    assign w_dbg_addr_x = c_SEL_ADDR_W'(i_dbg_addr);

    // The WB writer is locked out for the whole clear sequence.
    assign w_wr_ok = i_reg_write && w_idle && (w_wr_addr_x < c_DEPTH)
                     && !(c_ZERO && w_wr_addr_x == '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_write_reg] <= i_write_data;
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_read
        rd_sel_t            w_sel;
        logic [NB_DATA-1:0] w_val;
        logic [NB_DATA-1:0] r_port;

        always_comb begin
            w_sel = rd_select(i_link_sel[k],
                              c_SEL_ADDR_W'(i_read_reg[k*NB_ADDR +: NB_ADDR]),
                              c_LINK, i_reg_write, w_wr_addr_x, w_idle, c_BYP);
            if (c_ZERO && w_sel.addr == '0) begin
                w_val = '0;
            end else if (w_sel.bypass) begin
                w_val = i_write_data;
            end else if (w_sel.addr < c_DEPTH) begin
                w_val = r_regs[w_sel.addr[NB_ADDR-1:0]];
            end else begin
                w_val = '0;
            end
        end

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_port <= '0;
            end else if (!i_stall) begin
                r_port <= w_val;
            end
        end

        assign o_data[k*NB_DATA +: NB_DATA] = r_port;
    end

    // Debug port sees the array only: no bypass, no stall.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dbg <= '0;
        end else if ((c_ZERO && w_dbg_addr_x == '0) || w_dbg_addr_x >= c_DEPTH) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= r_regs[i_dbg_addr];
        end
    end

    assign o_dbg_data = r_dbg;

endmodule
`default_nettype wire
